// File: rtl/axi_wr_ingress.sv
// AXI4 write-channel ingress: expands AW/W bursts into addressed entries for the
// async write FIFO and returns the B response once the last beat is pushed.
module axi_wr_ingress #(
  parameter  int ADDR_W  = 32,
  parameter  int DATA_W  = 32,
  localparam int STRB_W  = DATA_W / 8,
  localparam int ENTRY_W = ADDR_W + DATA_W + STRB_W + 1
) (
  input  logic               wclk,
  input  logic               resetn,
  input  logic               awvalid,
  output logic               awready,
  input  logic [ADDR_W-1:0]  awaddr,
  input  logic [7:0]         awlen,
  input  logic [2:0]         awsize,
  input  logic [1:0]         awburst,
  input  logic               wvalid,
  output logic               wready,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [STRB_W-1:0]  wstrb,
  input  logic               wlast,
  output logic               bvalid,
  input  logic               bready,
  output logic [1:0]         bresp,
  output logic               fifo_wen,
  output logic [ENTRY_W-1:0] fifo_wdata,
  input  logic               fifo_full
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [7:0]        beat_cnt;
  // err_cfg: descriptor unusable, beats are drained without pushing.
  // err_proto: WLAST disagreed with the beat count; addresses are still valid so beats push.
  logic              err_cfg;
  logic              err_proto;
  logic              cfg_bad;
  logic              aw_hs;
  logic              w_hs;
  logic              is_last;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] addr_step;

  assign cfg_bad = (awburst == 2'b11)
                || ((32'd1 << awsize) > 32'(STRB_W))
                || ((awburst == 2'b10) && !((awlen == 8'd1) || (awlen == 8'd3) ||
                                            (awlen == 8'd7) || (awlen == 8'd15)));

  assign is_last    = (beat_cnt == len_q);
  assign fifo_wdata = {is_last, cur_addr, wstrb, wdata};

  always_comb begin
    incr      = ADDR_W'(1) << size_q;
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) * incr) - ADDR_W'(1);
    case (burst_q)
      2'b01:   addr_step = cur_addr + incr;
      2'b10:   addr_step = (cur_addr & ~wrap_mask) | ((cur_addr + incr) & wrap_mask);
      default: addr_step = cur_addr;
    endcase
  end

  always_comb begin
    state_nxt = state;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bresp     = 2'b00;
    fifo_wen  = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (state)
      S_IDLE: begin
        awready = 1'b1;
        aw_hs   = awvalid;
        if (awvalid) state_nxt = S_DATA;
      end
      S_DATA: begin
        wready   = !fifo_full || err_cfg;
        w_hs     = wvalid && wready;
        fifo_wen = w_hs && !err_cfg;
        if (w_hs && is_last) state_nxt = S_RESP;
      end
      S_RESP: begin
        bvalid = 1'b1;
        bresp  = (err_cfg || err_proto) ? 2'b10 : 2'b00;
        if (bready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge wclk or negedge resetn) begin
    if (!resetn) begin
      cur_addr  <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_cnt  <= '0;
      err_cfg   <= 1'b0;
      err_proto <= 1'b0;
    end else if (aw_hs) begin
      cur_addr  <= awaddr;
      len_q     <= awlen;
      size_q    <= awsize;
      burst_q   <= awburst;
      beat_cnt  <= '0;
      err_cfg   <= cfg_bad;
      err_proto <= 1'b0;
    end else if (w_hs) begin
      cur_addr <= addr_step;
      beat_cnt <= beat_cnt + 8'd1;
      if (wlast != is_last) err_proto <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_wr_ingress.sv
// Bench for axi_wr_ingress: directed vector table, reset/idle sequences and
// random bursts checked against an arithmetic burst model.
module tb_axi_wr_ingress;

  logic        wclk = 1'b0;
  logic        resetn;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        fifo_wen;
  logic [68:0] fifo_wdata;
  logic        fifo_full;

  axi_wr_ingress dut (
    .wclk(wclk), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full)
  );

  always #5 wclk = ~wclk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [68:0] got_q[$];
  int          last_base, last_n;
  logic [1:0]  last_bresp;

  always @(negedge wclk) if (resetn && fifo_wen) got_q.push_back(fifo_wdata);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic model_cfg_err(input logic [1:0] b, input int l, input int s);
    return (b == 2'b11) || ((1 << s) > 4) ||
           ((b == 2'b10) && !(l == 1 || l == 3 || l == 7 || l == 15));
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] a, input int l, input int s,
                                             input logic [1:0] b, input int k);
    longint unsigned inc, wl, base, av;
    inc = 64'd1 << s;
    av  = {32'd0, a};
    case (b)
      2'b01: return 32'(av + longint'(k) * inc);
      2'b10: begin
        wl   = longint'(l + 1) * inc;
        base = (av / wl) * wl;
        return 32'(base + ((av - base) + longint'(k) * inc) % wl);
      end
      default: return a;
    endcase
  endfunction

  // fmode: 0 never full, 1 random full, 2 full for 3 cycles after beat fk
  task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input int bad, input int fmode, input int fk);
    logic [31:0] dat [256];
    logic [3:0]  stb [256];
    logic [68:0] exp_q[$];
    logic        e_cfg, acc, wr_exp;
    logic [1:0]  er;
    int          i, cyc, hold, base_idx;
    e_cfg = model_cfg_err(b, int'(l), int'(s));
    for (int k = 0; k <= int'(l); k++) begin
      dat[k] = $urandom;
      stb[k] = 4'($urandom);
    end
    er = (e_cfg || (bad >= 0 && bad <= int'(l))) ? 2'b10 : 2'b00;
    if (!e_cfg)
      for (int k = 0; k <= int'(l); k++)
        exp_q.push_back({(k == int'(l)), model_addr(a, int'(l), int'(s), b, k), stb[k], dat[k]});
    base_idx = got_q.size();

    awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
    cyc = 0;
    do begin
      @(negedge wclk); acc = awready;
      @(posedge wclk); #1; cyc++;
    end while (!acc && cyc < 50);
    awvalid = 1'b0;
    chk("aw_handshake", acc, 1'b1);
    if (!acc) return;

    i = 0; cyc = 0; hold = 0;
    while (i <= int'(l) && cyc < 2000) begin
      wvalid = 1'b1;
      wdata  = dat[i];
      wstrb  = stb[i];
      wlast  = (i == int'(l)) ^ (i == bad);
      if (fmode == 1)      fifo_full = ($urandom_range(0, 3) == 0);
      else if (fmode == 2) fifo_full = (hold > 0);
      else                 fifo_full = 1'b0;
      wr_exp = !fifo_full || e_cfg;
      @(negedge wclk);
      chk("wready", wready, wr_exp);
      chk("fifo_wen", fifo_wen, wr_exp && !e_cfg);
      acc = wready;
      @(posedge wclk); #1; cyc++;
      if (hold > 0) hold--;
      if (acc) begin
        if (fmode == 2 && i == fk) hold = 3;
        i++;
      end
    end
    chk("beat_timeout", (cyc < 2000), 1'b1);
    wvalid = 1'b0; wlast = 1'b0; fifo_full = 1'b0;

    @(negedge wclk);
    chk("bvalid_latency", bvalid, 1'b1);
    chk("bresp", bresp, er);
    last_bresp = bresp;
    @(posedge wclk); #1;
    @(negedge wclk);
    chk("bvalid_hold", bvalid, 1'b1);
    chk("bresp_hold", bresp, er);
    bready = 1'b1;
    @(posedge wclk); #1;
    bready = 1'b0;
    @(negedge wclk);
    chk("bvalid_drop", bvalid, 1'b0);
    chk("awready_back", awready, 1'b1);
    @(posedge wclk); #1;

    last_base = base_idx;
    last_n    = got_q.size() - base_idx;
    chk("push_count", last_n, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < last_n; k++)
      chk($sformatf("push_entry%0d", k), got_q[base_idx + k], exp_q[k]);
  endtask

  typedef struct {
    logic [31:0]       addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    int                bad;
    int                fmode;
    int                fk;
    logic [1:0]        xresp;
    int                xn;
    logic [3:0][31:0]  xa;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                              input logic [1:0] b, input int bad, input int fm, input int fk,
                              input logic [1:0] xr, input int xn,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.addr = a; v.len = l; v.size = s; v.burst = b; v.bad = bad; v.fmode = fm; v.fk = fk;
    v.xresp = xr; v.xn = xn;
    v.xa[0] = a0; v.xa[1] = a1; v.xa[2] = a2; v.xa[3] = a3;
    return v;
  endfunction

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, l, bad;
    logic [1:0] b;
    vt[0]  = mk(32'h100, 3, 2, 2'b01, -1, 0, 0, 2'b00, 4, 32'h100, 32'h104, 32'h108, 32'h10C);
    vt[1]  = mk(32'h108, 3, 2, 2'b10, -1, 0, 0, 2'b00, 4, 32'h108, 32'h10C, 32'h100, 32'h104);
    vt[2]  = mk(32'h100, 7, 2, 2'b01, -1, 2, 1, 2'b00, 8, 32'h100, 32'h104, 32'h108, 32'h10C);
    vt[3]  = mk(32'h200, 1, 2, 2'b11, -1, 0, 0, 2'b10, 0, 0, 0, 0, 0);
    vt[4]  = mk(32'h200, 3, 2, 2'b01,  1, 0, 0, 2'b10, 4, 32'h200, 32'h204, 32'h208, 32'h20C);
    vt[5]  = mk(32'h300, 0, 0, 2'b01, -1, 0, 0, 2'b00, 1, 32'h300, 0, 0, 0);
    vt[6]  = mk(32'h40,  2, 1, 2'b00, -1, 0, 0, 2'b00, 3, 32'h40, 32'h40, 32'h40, 0);
    vt[7]  = mk(32'h400, 2, 2, 2'b10, -1, 0, 0, 2'b10, 0, 0, 0, 0, 0);
    vt[8]  = mk(32'h500, 1, 3, 2'b01, -1, 0, 0, 2'b10, 0, 0, 0, 0, 0);
    vt[9]  = mk(32'h600, 1, 2, 2'b01,  1, 0, 0, 2'b10, 2, 32'h600, 32'h604, 0, 0);
    vt[10] = mk(32'hFFFF_FFFC, 1, 2, 2'b01, -1, 1, 0, 2'b00, 2, 32'hFFFF_FFFC, 32'h0, 0, 0);

    resetn = 1'b0; awvalid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0; fifo_full = 0;
    repeat (3) @(posedge wclk);
    #1 resetn = 1'b1;
    @(negedge wclk);
    chk("rst_awready", awready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_fifo_wen", fifo_wen, 1'b0);
    @(posedge wclk); #1;

    // W beat offered while idle must not be taken
    wvalid = 1'b1; wdata = 32'hDEAD; wlast = 1'b1;
    @(negedge wclk);
    chk("idle_wready", wready, 1'b0);
    chk("idle_fifo_wen", fifo_wen, 1'b0);
    @(posedge wclk); #1;
    wvalid = 1'b0; wlast = 1'b0;

    foreach (vt[v]) begin
      run_burst(vt[v].addr, vt[v].len, vt[v].size, vt[v].burst, vt[v].bad, vt[v].fmode, vt[v].fk);
      chk($sformatf("tbl%0d_bresp", v), last_bresp, vt[v].xresp);
      chk($sformatf("tbl%0d_npush", v), last_n, vt[v].xn);
      for (int k = 0; k < vt[v].xn && k < 4 && k < last_n; k++)
        chk($sformatf("tbl%0d_addr%0d", v, k), got_q[last_base + k][67:36], vt[v].xa[k]);
      for (int k = 0; k < last_n; k++)
        chk($sformatf("tbl%0d_last%0d", v, k), got_q[last_base + k][68], (k == vt[v].xn - 1));
    end

    // reset in the middle of a burst
    base = got_q.size();
    awaddr = 32'h700; awlen = 3; awsize = 2; awburst = 2'b01; awvalid = 1'b1;
    @(posedge wclk); #1;
    awvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wvalid = 1'b1; wdata = 32'hB0 + k; wstrb = 4'hF; wlast = 1'b0;
      @(negedge wclk);
      chk("rstmid_wready", wready, 1'b1);
      @(posedge wclk); #1;
    end
    wvalid = 1'b0;
    resetn = 1'b0;
    #2;
    chk("rstmid_awready", awready, 1'b1);
    chk("rstmid_wready_low", wready, 1'b0);
    chk("rstmid_bvalid", bvalid, 1'b0);
    @(posedge wclk); #1;
    resetn = 1'b1;
    @(negedge wclk);
    chk("rstmid_bvalid_after", bvalid, 1'b0);
    chk("rstmid_awready_after", awready, 1'b1);
    chk("rstmid_pushes", got_q.size() - base, 2);
    @(posedge wclk); #1;
    run_burst(32'h800, 3, 2, 2'b01, -1, 0, 0);
    chk("rstmid_fresh_bresp", last_bresp, 2'b00);

    // random bursts against the model
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0:             b = 2'b11;
        1, 2:          b = 2'b00;
        3, 4, 5, 6:    b = 2'b01;
        default:       b = 2'b10;
      endcase
      if (b == 2'b10 && $urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 3))
          0: l = 1; 1: l = 3; 2: l = 7; default: l = 15;
        endcase
      end else l = $urandom_range(0, 15);
      bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, l) : -1;
      run_burst($urandom, 8'(l), 3'($urandom_range(0, 3)), b, bad, 1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_wr_ingress.md
# axi_wr_ingress

Write-channel front end of the AXI-to-AHB bridge, running on the AXI write clock `wclk`. It accepts AXI4 write bursts on the AW and W channels and expands each data beat into a fully addressed entry. It pushes those entries into the asynchronous write FIFO, which crosses them to the AHB side, and returns the B-channel response once the burst's last beat has been pushed. It is the direct upstream producer of the write FIFO.

## Interface

**Parameters**

- `ADDR_W`, default 32: AXI/AHB address width.
- `DATA_W`, default 32: data bus width. Legal values are 32 or 64. `STRB_W = DATA_W/8`.
- `ENTRY_W`, derived, not overridable: `ADDR_W + DATA_W + STRB_W + 1`.

**Ports**

- `wclk` in 1: write-side clock. All logic is on its rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `awvalid` in 1, `awready` out 1: AW handshake.
- `awaddr` in ADDR_W, `awlen` in 8, `awsize` in 3, `awburst` in 2: burst descriptor.
- `wvalid` in 1, `wready` out 1: W handshake.
- `wdata` in DATA_W, `wstrb` in STRB_W, `wlast` in 1: beat payload.
- `bvalid` out 1, `bready` in 1, `bresp` out 2: write response.
- `fifo_wen` out 1: push strobe to the write FIFO.
- `fifo_wdata` out ENTRY_W: pushed entry, packed as {last, addr, strb, data}.
- `fifo_full` in 1: write FIFO full, already in the `wclk` domain.

## Operation

**States:** IDLE, DATA, RESP. Encoding is free.

**IDLE**
- `awready`=1.
- On `awvalid`&&`awready`, capture addr, len, size and burst, then go to DATA.
- Set `beat_cnt`=0.
- Set `err`=1 if `awburst`==2'b11, or if (1<<`awsize`) > `STRB_W`.

**DATA**
- `wready` = !`fifo_full` || `err`.
- Beat accepted when `wvalid`&&`wready`.
  - `fifo_wen` = accepted && !`err`. This is combinational, so there is no overflow window against `fifo_full`.
  - `fifo_wdata` = {`beat_cnt`==len, cur_addr, `wstrb`, `wdata`}.
  - `beat_cnt` increments.
- Address update per accepted beat, with incr = 1<<size:
  - FIXED (00): unchanged.
  - INCR (01): cur_addr + incr. Width is ADDR_W and wraps modulo 2^ADDR_W.
  - WRAP (10): wrap_len = (len+1)*incr and base = cur_addr & ~(wrap_len-1). The next address is base | ((cur_addr+incr) & (wrap_len-1)).
  - For WRAP, len ∉ {1,3,7,15} sets `err` at AW capture.
- Protocol checks on each accepted beat:
  - `wlast`=1 when `beat_cnt`!=len sets a sticky `err`.
  - `wlast`=0 on beat `beat_cnt`==len sets a sticky `err`.
  - Beats already pushed remain pushed.
  - The burst length is always governed by `beat_cnt`, never by `wlast`.
- After the beat with `beat_cnt`==len is accepted, go to RESP.

**RESP**
- `bvalid`=1.
- `bresp` = `err` ? 2'b10 (SLVERR) : 2'b00 (OKAY).
- `bresp` and `bvalid` stay stable until `bready`, then go to IDLE.

**Outside their states**
- `awready`=0 outside IDLE.
- `wready`=0 outside DATA.
- `bvalid`=0 outside RESP.
- Only one outstanding burst. W beats presented in IDLE are not accepted.

## Timing

**Reset values**
- `resetn` low asynchronously forces IDLE.
- Outputs: `awready`=1, `wready`=0, `bvalid`=0, `bresp`=00, `fifo_wen`=0.
- Reset also clears `beat_cnt`, cur_addr and `err`.

**Latency**
- AW accepted at edge T. `wready` can be high in cycle T+1.
- A beat accepted at edge T pushes in that same cycle: `fifo_wen` is high before edge T.
- The last beat accepted at edge T gives `bvalid` in cycle T+1.
- B handshake at edge T gives `awready`=1 in cycle T+1.
- Best-case throughput is len+3 cycles per burst.

**Back-pressure and reset**
- While `fifo_full`=1 and `err`=0: `wready`=0 and `fifo_wen`=0. The beat is held by the master.
- Reset mid-burst drops the burst. No B is issued, and entries already pushed stay in the FIFO.

## Test plan

- **INCR baseline:** INCR, len=3, size=2, addr=0x100, data 0xA0..0xA3 → 4 pushes with addrs 0x100/104/108/10C, last=1 only on 4th, `bresp`=00, `bvalid` one cycle after last beat.
- **WRAP:** WRAP, len=3, size=2, addr=0x108 → addrs 0x108, 0x10C, 0x100, 0x104.
- **FIFO full back-pressure:** INCR len=7, `fifo_full` forced high for 3 cycles after beat 2 → `wready`=0 and `fifo_wen`=0 for exactly those cycles, then 8 pushes total in order.
- **Reserved burst:** `awburst`=11, len=1 → both W beats accepted, zero pushes, `bresp`=10.
- **Early WLAST:** INCR len=3 with `wlast`=1 on beat 1 → 4 beats still consumed and pushed, `bresp`=10. The next burst returns 00.
- **Reset mid-burst:** assert `resetn` low after beat 1 of len=3 → `bvalid`=0, `awready`=1 after release, and a fresh burst completes normally.
